// File: rtl/pool_pkg.sv
// ============================================================================
// Module  : pool_pkg
// Purpose : Shared state encoding and geometry helpers for the layer-1 max pool.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pool_pkg;

  localparam int ADDR_W = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_WRITE  = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  function automatic int data_w(input int integer_width, input int fraction_width);
    return integer_width + fraction_width;
  endfunction

  function automatic int out_size(input int in_size, input int pool);
    return in_size / pool;
  endfunction

  function automatic int windows(input int in_size, input int pool);
    return out_size(in_size, pool) * out_size(in_size, pool);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pool_output_ram.sv
// ============================================================================
// Module  : pool_output_ram
// Purpose : Single-port synchronous RAM holding the pooled feature map.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_output_ram
  import pool_pkg::*;
#(
  parameter int DEPTH  = 169,
  parameter int DATA_W = 20,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/maxpool2d_layer1.sv
// ============================================================================
// Module  : maxpool2d_layer1
// Purpose : 2x2 stride-2 signed max pool of the layer-1 conv buffer into a
//           13x13 result RAM served through a registered read port.
//           Optional macro MAXPOOL_RELU_EN clamps negative maxima to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool2d_layer1
  import pool_pkg::*;
#(
  parameter int IN_SIZE        = 26,
  parameter int POOL           = 2,
  parameter int INTEGER_WIDTH  = 10,
  parameter int FRACTION_WIDTH = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  output logic [ADDR_W-1:0]                                in_address,
  output logic                                             in_enable,
  input  logic [data_w(INTEGER_WIDTH, FRACTION_WIDTH)-1:0] in_data,
  input  logic [ADDR_W-1:0]                                out_address,
  input  logic                                             out_enable,
  output logic [data_w(INTEGER_WIDTH, FRACTION_WIDTH)-1:0] out_data,
  output logic                                             done
);

  localparam int DATA_W   = data_w(INTEGER_WIDTH, FRACTION_WIDTH);
  localparam int OUT_SIZE = out_size(IN_SIZE, POOL);
  localparam int WINDOWS  = windows(IN_SIZE, POOL);
  localparam int RAM_AW   = (WINDOWS > 2) ? $clog2(WINDOWS) : 1;

  localparam logic [ADDR_W-1:0] C_LAST_IDX  = ADDR_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] C_WINDOWS   = ADDR_W'(WINDOWS);
  localparam logic [7:0]        C_WAIT_LAST = 8'(READ_LATENCY - 2);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   r_q, r_d;
  logic [ADDR_W-1:0]   c_q, c_d;
  logic [1:0]          k_q, k_d;
  logic [7:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
  logic                sel_q, sel_d;

  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_ram_we;
  logic                w_ram_en;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_out_ok;

  // Sample k walks the window row-major: bit 0 selects column, bit 1 row.
  assign w_rd_addr = ADDR_W'((POOL * r_q + k_q[1]) * IN_SIZE + POOL * c_q + k_q[0]);

  assign in_enable  = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign in_address = (state_q == S_ADDR) ? w_rd_addr : in_addr_q;
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    wait_d    = wait_q;
    max_d     = max_q;
    in_addr_d = in_address;
    w_ram_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end
      S_ADDR: begin
        wait_d  = '0;
        state_d = (READ_LATENCY > 1) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        if (wait_q == C_WAIT_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        // Strict greater-than keeps the earlier sample on ties.
        if ((k_q == 2'd0) || ($signed(in_data) > $signed(max_q))) begin
          max_d = in_data;
        end
        if (k_q == 2'd3) begin
          state_d = S_WRITE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_ADDR;
        end
      end
      S_WRITE: begin
        w_ram_we = 1'b1;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        k_d = '0;
        if (c_q == C_LAST_IDX) begin
          c_d = '0;
          if (r_q == C_LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            r_d     = r_q + 1'b1;
            state_d = S_ADDR;
          end
        end else begin
          c_d     = c_q + 1'b1;
          state_d = S_ADDR;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MAXPOOL_RELU_EN
  assign w_wdata = max_q[DATA_W-1] ? '0 : max_q;
`else
  assign w_wdata = max_q;
`endif

  // The RAM port belongs to the FSM until done, then to the layer-2 reader.
  assign w_out_ok   = done && out_enable && (out_address < C_WINDOWS);
  assign w_ram_en   = w_ram_we || w_out_ok;
  assign w_ram_addr = done ? RAM_AW'(out_address) : RAM_AW'(r_q * OUT_SIZE + c_q);

  always_comb begin
    sel_d = sel_q;
    if (!done) begin
      sel_d = 1'b0;
    end else if (out_enable) begin
      sel_d = w_out_ok;
    end
  end

  assign out_data = (done && sel_q) ? w_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      wait_q    <= '0;
      max_q     <= '0;
      in_addr_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      k_q       <= k_d;
      wait_q    <= wait_d;
      max_q     <= max_d;
      in_addr_q <= in_addr_d;
      sel_q     <= sel_d;
    end
  end

  pool_output_ram #(
    .DEPTH  (WINDOWS),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_maxpool2d_layer1.sv
// ============================================================================
// Module  : tb_maxpool2d_layer1
// Purpose : Directed self-checking bench for maxpool2d_layer1 with an upstream
//           two-cycle BRAM model and a readout scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maxpool2d_layer1;

  localparam int IN       = 26;
  localparam int OS       = 13;
  localparam int WIN      = OS * OS;
  localparam int RL       = 2;
  localparam int RD_CYC   = 4 * (RL + 1);
  localparam int PER_WIN  = RD_CYC + 2;
  localparam int DONE_CYC = WIN * PER_WIN + 1;
  localparam int LAST_A   = (2 * (OS - 1) + 1) * IN + 2 * (OS - 1) + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] in_address;
  logic        in_enable;
  logic [19:0] in_data;
  logic [12:0] out_address;
  logic        out_enable;
  logic [19:0] out_data;
  logic        done;

  logic [19:0] mem [0:IN*IN-1];
  logic [19:0] p1, p2;
  logic [19:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  maxpool2d_layer1 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_address  (in_address),
    .in_enable   (in_enable),
    .in_data     (in_data),
    .out_address (out_address),
    .out_enable  (out_enable),
    .out_data    (out_data),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_enable) begin
      p1 <= (in_address < 13'(IN * IN)) ? mem[in_address] : 20'd0;
    end
    p2 <= p1;
  end
  assign in_data = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [19:0] smax(input logic [19:0] a, input logic [19:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

  // Values past address 511 wrap negative in Q10.10, so this is a true signed max.
  function automatic logic [19:0] ref_out(input int a);
    int r, c, base;
    logic [19:0] m;
    if (a >= WIN) return 20'd0;
    r    = a / OS;
    c    = a % OS;
    base = 2 * r * IN + 2 * c;
    m = mem[base];
    m = smax(m, mem[base + 1]);
    m = smax(m, mem[base + IN]);
    m = smax(m, mem[base + IN + 1]);
`ifdef MAXPOOL_RELU_EN
    if (m[19]) m = 20'd0;
`endif
    return m;
  endfunction

  // Entered at a negedge; that cycle is cycle 0 of the run.
  task automatic run_pool(input int ncyc);
    int w, p, k, r, c, a;
    start       = 1'b1;
    out_enable  = 1'b1;
    out_address = 13'd0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 3) start = 1'b0;
      if (n < DONE_CYC) begin
        w = (n - 1) / PER_WIN;
        p = (n - 1) % PER_WIN;
        k = (p < RD_CYC) ? p / (RL + 1) : 3;
        r = w / OS;
        c = w % OS;
        a = (2 * r + k / 2) * IN + 2 * c + k % 2;
        chk("in_enable", in_enable, (p < RD_CYC) ? 1 : 0);
        chk("in_address", in_address, a);
        chk("done_low", done, 0);
        chk("out_data_pre_done", out_data, 0);
      end else begin
        chk("in_enable_done", in_enable, 0);
        chk("in_address_done", in_address, LAST_A);
        chk("done_rise", done, 1);
      end
    end
  endtask

  task automatic read_chk(input string tag, input int a, input logic [19:0] expv);
    out_address = 13'(a);
    out_enable  = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    chk(tag, out_data, exp_q.pop_front());
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b1;
    out_enable  = 1'b0;
    out_address = 13'd0;
    p1          = 20'd0;
    p2          = 20'd0;
    for (int a = 0; a < IN * IN; a++) mem[a] = 20'(a << 10);

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_in_enable", in_enable, 0);
    chk("rst_in_address", in_address, 0);
    chk("rst_out_data", out_data, 0);

    reset = 1'b1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_in_enable", in_enable, 0);
      chk("idle_done", done, 0);
    end

    // Full pool with address/timing trace, then full readout
    run_pool(DONE_CYC);
    for (int a = 0; a < WIN; a++) read_chk("pool_all", a, ref_out(a));
    read_chk("out0", 0, 20'(27 << 10));
    read_chk("out12", 12, 20'(51 << 10));
`ifdef MAXPOOL_RELU_EN
    read_chk("out168", 168, 20'd0);
`else
    read_chk("out168", 168, 20'(675 << 10));
`endif

    // start toggling after done must not restart reads
    repeat (20) begin
      @(negedge clk);
      start = ~start;
      chk("post_done_in_enable", in_enable, 0);
      chk("post_done_done", done, 1);
      chk("post_done_in_address", in_address, LAST_A);
    end
    start = 1'b0;
    read_chk("out5", 5, 20'(37 << 10));
    read_chk("out_oob", 200, 20'd0);

    // Reset in the middle of a run, then a complete re-pool
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_pool(1000);
    reset = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_in_enable", in_enable, 0);
    chk("mid_rst_in_address", in_address, 0);
    chk("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_pool(DONE_CYC);
    for (int a = 0; a < WIN; a++) read_chk("repool_all", a, ref_out(a));

    // Negative window and a tied window
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem[0]  = 20'(-5 * 1024);
    mem[1]  = 20'(-3 * 1024);
    mem[26] = 20'(-8 * 1024);
    mem[27] = 20'(-1 * 1024);
    mem[2]  = 20'(2 * 1024);
    mem[3]  = 20'(7 * 1024);
    mem[28] = 20'(7 * 1024);
    mem[29] = 20'(1 * 1024);
    @(negedge clk);
    run_pool(DONE_CYC);
`ifdef MAXPOOL_RELU_EN
    read_chk("neg_window", 0, 20'd0);
`else
    read_chk("neg_window", 0, 20'(-1024));
`endif
    read_chk("tie_window", 1, 20'(7 * 1024));
    for (int a = 2; a < WIN; a++) read_chk("neg_run_all", a, ref_out(a));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
